qar_gpio_arbiter: RTL and testbench
===================================

Name: qar_gpio_arbiter

Overview:
- Shares the single GPIO register port (write_en/read_en/addr_word/wdata/rdata) among NREQ bus masters, e.g. CPU load/store unit and a PWM/pattern engine.
- Round-robin arbitration with valid/ready request handshake and a fixed-latency response.
- Optional bus lock keeps the grant on one requester for atomic read-modify-write sequences.
- Sits between the requesters and qar_gpio; the GPIO block itself is unchanged.

Parameters:
NREQ, 2, number of requesters (2..8)
LOCK_MAX, 16, idle cycles an owner may hold a lock without issuing before forced release (1..255)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req_valid  input  NREQ  per-requester command valid
req_write  input  NREQ  1=write, 0=read
req_lock  input  NREQ  1=retain grant after this command
req_addr  input  5*NREQ  word address, requester i at [5i+4:5i]
req_wdata  input  32*NREQ  write data, requester i at [32i+31:32i]
req_ready  output  NREQ  command accepted this cycle (valid&ready)
rsp_valid  output  NREQ  one-cycle response strobe for requester i
rsp_rdata  output  32  read data (0 for write acks); meaningful only with rsp_valid
lock_timeout  output  1  one-cycle pulse on forced lock release
gpio_write_en  output  1  to qar_gpio write_en
gpio_read_en  output  1  to qar_gpio read_en
gpio_addr_word  output  5  to qar_gpio addr_word
gpio_wdata  output  32  to qar_gpio wdata
gpio_rdata  input  32  from qar_gpio rdata (combinational on read_en)

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, rr pointer=0, lock_owned=0, lock counter=0, pipeline stages invalid; in-flight commands are dropped with no rsp_valid.
- Arbitration (cycle T, combinational): if no lock held, winner = first i with req_valid[i] searching from rr pointer upward, wrapping mod NREQ; req_ready[winner]=1, all others 0. At most one req_ready bit is high.
- On accept: rr pointer <= winner+1 mod NREQ, unless the command sets req_lock=1.
- Lock held by owner o: req_ready can be high only for o, and only when req_valid[o]. The rr pointer is frozen.
  - An accepted command from o with req_lock=0 releases the lock; the pointer then becomes o+1.
  - An accepted command with req_lock=1 keeps the lock.
- Lock timeout: counter resets to 0 on each accept by o and increments each cycle o is not valid. When it reaches LOCK_MAX, the lock is released that cycle, lock_timeout pulses, the pointer becomes o+1, and arbitration resumes the next cycle.
- Issue stage (T+1): the registered command drives gpio_*; gpio_write_en or gpio_read_en is high for exactly one cycle. gpio_wdata=0 for reads.
- Response stage (T+2): rsp_valid[winner]=1 for one cycle. rsp_rdata = gpio_rdata captured at T+1 for reads, 0 for writes.
- Fully pipelined: one command per cycle sustained; back-to-back accepts from different requesters are allowed, and responses come back in accept order.
- No backpressure on responses; requesters must sink rsp_valid.
- gpio_* outputs are 0 in any cycle with no issued command.
- The arbiter performs no address decoding; any 5-bit address passes through.
- Write-1-clear to IRQ_STATUS and OUT_SET/OUT_CLR semantics are unaffected because the arbiter is a pure pass-through.
- Simultaneous lock timeout and new owner valid in the same cycle: the timeout wins; the owner re-arbitrates normally the next cycle.

Test Plan:
- Single read: req0 valid, read addr 2 at T, gpio_in=0x0000_00A5 with dir=0 → req_ready[0] at T, gpio_read_en/addr 2 at T+1, rsp_valid[0] with rsp_rdata=0x0000_00A5 at T+2.
- Round-robin: req0 and req1 both valid continuously with writes to addr 3 → grants alternate 0,1,0,1; 4 accepts in 4 cycles; gpio_wdata follows the grant order.
- Lock RMW: req0 reads addr 1 with lock=1 while req1 is valid; req0 then writes 0x5 to addr 1 with lock=0 → req1 gets no ready until the cycle after the req0 write is accepted; read rsp precedes write ack.
- Lock timeout (LOCK_MAX=16): req0 locks then goes idle, req1 valid → lock_timeout pulses 16 cycles after the last req0 accept; req1 is accepted the next cycle.
- Reset mid-flight: assert rst in the cycle gpio_write_en=1 → the next cycle all outputs are 0, no rsp_valid, and the rr pointer restarts at requester 0.

Source files
------------

// File: rtl/qar_gpio_arbiter_if.sv
// qar_gpio_arbiter_if: requester handshake and qar_gpio register-port bundle
interface qar_gpio_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_lock;
  logic [5*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               lock_timeout;
  logic               gpio_write_en;
  logic               gpio_read_en;
  logic [4:0]         gpio_addr_word;
  logic [31:0]        gpio_wdata;
  logic [31:0]        gpio_rdata;
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata, gpio_rdata,
    output req_ready, rsp_valid, rsp_rdata, lock_timeout,
           gpio_write_en, gpio_read_en, gpio_addr_word, gpio_wdata
  );
  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata, gpio_rdata,
    input  req_ready, rsp_valid, rsp_rdata, lock_timeout,
           gpio_write_en, gpio_read_en, gpio_addr_word, gpio_wdata
  );
endinterface

// File: rtl/qar_gpio_arbiter.sv
// qar_gpio_arbiter: round-robin arbiter with bus lock sharing one qar_gpio register port
module qar_gpio_arbiter #(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 16
) (
  input logic               clk,
  input logic               rst,
  qar_gpio_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win, win_rr, nxt, idx;
  logic            lock_q, lock_d, iss_w_q, iss_w_d, timeout, accept;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      iss_a_q, iss_a_d;
  logic [31:0]     iss_d_q, iss_d_d, rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] iss_oh_q, iss_oh_d, rsp_oh_q, rsp_oh_d;
  always_comb begin
    idx = '0;
    win_rr = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      win_rr = bus.req_valid[idx] ? idx : win_rr;
    end
    // the timeout wins even if the owner shows up in the same cycle
    timeout = lock_q && cnt_q == 8'(LOCK_MAX - 1);
    win = lock_q ? owner_q : win_rr;
    accept = !rst && (lock_q ? bus.req_valid[owner_q] && !timeout : |bus.req_valid);
    nxt = win == PW'(NREQ - 1) ? '0 : win + 1'b1;
    ptr_d = (accept && !bus.req_lock[win]) || timeout ? nxt : ptr_q;
    lock_d = accept ? bus.req_lock[win] : lock_q && !timeout;
    owner_d = accept ? win : owner_q;
    cnt_d = accept || timeout || !lock_q ? '0 : cnt_q + {7'd0, !bus.req_valid[owner_q]};
    iss_w_d = accept && bus.req_write[win];
    iss_a_d = accept ? bus.req_addr[5*win +: 5] : '0;
    iss_d_d = iss_w_d ? bus.req_wdata[32*win +: 32] : '0;
    iss_oh_d = accept ? NREQ'(1) << win : '0;
    rsp_oh_d = iss_oh_q;
    rsp_data_d = |iss_oh_q && !iss_w_q ? bus.gpio_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      iss_w_q    <= 1'b0;
      iss_a_q    <= '0;
      iss_d_q    <= '0;
      iss_oh_q   <= '0;
      rsp_oh_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      iss_w_q    <= iss_w_d;
      iss_a_q    <= iss_a_d;
      iss_d_q    <= iss_d_d;
      iss_oh_q   <= iss_oh_d;
      rsp_oh_q   <= rsp_oh_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign bus.req_ready      = accept ? NREQ'(1) << win : '0;
  assign bus.lock_timeout   = timeout && !rst;
  assign bus.gpio_write_en  = iss_w_q;
  assign bus.gpio_read_en   = |iss_oh_q && !iss_w_q;
  assign bus.gpio_addr_word = iss_a_q;
  assign bus.gpio_wdata     = iss_d_q;
  assign bus.rsp_valid      = rsp_oh_q;
  assign bus.rsp_rdata      = rsp_data_q;
endmodule

// File: tb/tb_qar_gpio_arbiter.sv
// tb_qar_gpio_arbiter: randomized requesters, GPIO register model, queued scoreboard
module tb_qar_gpio_arbiter;
  localparam int NREQ = 3, LOCK_MAX = 16;
  logic clk = 1'b0, rst = 1'b1, boot = 1'b1;
  always #5 clk = ~clk;
  qar_gpio_arbiter_if #(.NREQ(NREQ)) bus ();
  qar_gpio_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] gmem [32];
  assign bus.gpio_rdata = bus.gpio_read_en ? gmem[bus.gpio_addr_word] : '0;
  always @(posedge clk)
    if (boot) for (int i = 0; i < 32; i++) gmem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
    else if (bus.gpio_write_en) gmem[bus.gpio_addr_word] <= bus.gpio_wdata;
  typedef struct {int cyc; bit w; logic [4:0] a; logic [31:0] d; int id;} ev_t;
  ev_t iq[$], rq[$];
  int checks = 0, errors = 0, cyc = 0, ntimeout = 0;
  int ptr = 0, owner = 0, last_acc = 0;
  bit locked = 1'b0;
  logic [31:0] mref [32];
  int sleep [NREQ];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    int w;
    bit to;
    cyc++;
    if (boot) for (int i = 0; i < 32; i++) mref[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    if (bus.gpio_write_en || bus.gpio_read_en) begin
      if (iq.size() == 0) chk("issue_unexpected", 32'(iq.size()), 1);
      else begin
        e = iq.pop_front();
        chk("issue_cyc", cyc, e.cyc);
        chk("issue_we", 32'(bus.gpio_write_en), 32'(e.w));
        chk("issue_re", 32'(bus.gpio_read_en), 32'(!e.w));
        chk("issue_addr", 32'(bus.gpio_addr_word), 32'(e.a));
        chk("issue_wdata", bus.gpio_wdata, e.d);
      end
    end else begin
      if (iq.size() != 0 && iq[0].cyc <= cyc) begin
        chk("issue_missing", 32'(bus.gpio_read_en | bus.gpio_write_en), 1);
        void'(iq.pop_front());
      end
      chk("idle_addr", 32'(bus.gpio_addr_word), 0);
      chk("idle_wdata", bus.gpio_wdata, 0);
    end
    if (bus.rsp_valid != '0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
      else begin
        e = rq.pop_front();
        chk("rsp_cyc", cyc, e.cyc);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
        chk("rsp_rdata", bus.rsp_rdata, e.d);
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      chk("rsp_missing", 32'(bus.rsp_valid), 32'(1) << rq[0].id);
      void'(rq.pop_front());
    end
    if (rst) begin
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_timeout", 32'(bus.lock_timeout), 0);
      iq.delete();
      rq.delete();
      ptr = 0;
      locked = 1'b0;
    end else begin
      to = locked && (cyc - last_acc == LOCK_MAX);
      w = -1;
      if (locked) w = (bus.req_valid[owner] && !to) ? owner : -1;
      else for (int k = 0; k < NREQ; k++) if (w < 0 && bus.req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
      chk("req_ready", 32'(bus.req_ready), w < 0 ? 32'd0 : 32'(1) << w);
      chk("lock_timeout", 32'(bus.lock_timeout), 32'(to));
      if (to) ntimeout++;
      if (w >= 0) begin
        e.id = w;
        e.w = bus.req_write[w];
        e.a = bus.req_addr[5*w +: 5];
        e.d = e.w ? bus.req_wdata[32*w +: 32] : '0;
        e.cyc = cyc + 1;
        iq.push_back(e);
        e.cyc = cyc + 2;
        e.d = e.w ? 32'd0 : mref[e.a];
        rq.push_back(e);
        if (e.w) mref[e.a] = bus.req_wdata[32*w +: 32];
        last_acc = cyc;
        locked = bus.req_lock[w];
        owner = w;
        if (!locked) ptr = (w + 1) % NREQ;
      end else if (to) begin
        locked = 1'b0;
        ptr = (owner + 1) % NREQ;
      end
    end
  end
  initial begin
    logic [NREQ-1:0] acc;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    boot = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1 rst = (c == 1200 || c == 2600);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          bus.req_valid[i] = 1'b0;
          if ($urandom_range(0, 5) == 0) sleep[i] = int'($urandom_range(8, 24));
        end
        if (sleep[i] > 0) sleep[i]--;
        else if (!bus.req_valid[i] && $urandom_range(0, 3) != 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_write[i] = 1'($urandom_range(0, 1));
          bus.req_lock[i] = ($urandom_range(0, 3) == 0);
          bus.req_addr[5*i +: 5] = 5'($urandom_range(0, 7));
          bus.req_wdata[32*i +: 32] = $urandom;
        end
      end
    end
    bus.req_valid = '0;
    repeat (LOCK_MAX + 4) @(negedge clk);
    chk("issue_drain", 32'(iq.size()), 0);
    chk("rsp_drain", 32'(rq.size()), 0);
    chk("timeout_seen", 32'(ntimeout > 0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
